// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ valid/ready requesters.
// Optional: FIFO_ARB_ALMFULL_THROTTLE_EN holds off new bursts while the FIFO is almost full.
module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DW        = 128,
    parameter int MAX_BURST = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      i_req_valid,
    input  logic [N_REQ-1:0]      i_req_last,
    input  logic [N_REQ*DW-1:0]   i_req_data,
    output logic [N_REQ-1:0]      o_req_ready,
    input  logic                  i_full,
    input  logic                  i_alm_full,
    output logic                  o_wren,
    output logic [DW-1:0]         o_wrdata,
    output logic [N_REQ-1:0]      o_grant,
    output logic                  o_busy
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    logic [0:0]    state;
    logic [IW-1:0] g;
    logic [IW-1:0] p;
    logic [7:0]    cnt;

    logic [IW-1:0] sel;
    logic          start;
    logic          accept;
    logic          end_burst;
    logic [N_REQ-1:0] g_onehot;

    // Scan p+1, p+2, ... so the last owner has lowest priority.
    always_comb begin
        logic found;
        logic [IW-1:0] idx;
        found = 1'b0;
        sel   = p;
        idx   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = IW'((int'(p) + i) % N_REQ);
            if (!found && i_req_valid[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

`ifdef FIFO_ARB_ALMFULL_THROTTLE_EN
    assign start = (state == S_IDLE) && (|i_req_valid) && !i_alm_full;
`else
    logic unused_alm_full;
    assign unused_alm_full = i_alm_full;
    assign start = (state == S_IDLE) && (|i_req_valid);
`endif

    assign g_onehot  = N_REQ'(1) << g;
    assign accept    = (state == S_BURST) && i_req_valid[g] && !i_full;
    assign end_burst = accept && (i_req_last[g] || (cnt == 8'(MAX_BURST - 1)));

    assign o_busy      = (state == S_BURST);
    assign o_grant     = o_busy ? g_onehot : '0;
    assign o_wren      = accept;
    assign o_req_ready = accept ? g_onehot : '0;
    assign o_wrdata    = accept ? i_req_data[g*DW +: DW] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            g     <= '0;
            p     <= IW'(N_REQ - 1);
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        g     <= sel;
                        cnt   <= '0;
                        state <= S_BURST;
                    end
                end
                default: begin
                    if (accept)
                        cnt <= cnt + 8'd1;
                    if (end_burst) begin
                        p     <= g;
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (N_REQ=4, DW=128, MAX_BURST=4).
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int DW = 128;
    localparam int MB = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_last = '0;
    logic [N*DW-1:0]   req_data = '0;
    logic [N-1:0]      req_ready;
    logic              full = 1'b0;
    logic              alm_full = 1'b0;
    logic              wren;
    logic [DW-1:0]     wrdata;
    logic [N-1:0]      grant;
    logic              busy;

    int n_chk = 0;
    int n_pass = 0;

    fifo_wr_arbiter #(.N_REQ(N), .DW(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .reset(reset),
        .i_req_valid(req_valid), .i_req_last(req_last), .i_req_data(req_data),
        .o_req_ready(req_ready), .i_full(full), .i_alm_full(alm_full),
        .o_wren(wren), .o_wrdata(wrdata), .o_grant(grant), .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setreq(input int k, input logic v, input logic l, input logic [DW-1:0] d);
        req_valid[k] = v;
        req_last[k]  = l;
        req_data[k*DW +: DW] = d;
    endtask

    // Check the combinational beat outputs one settle step after inputs change.
    task automatic beat(input string tag, input logic [N-1:0] gexp, input logic wexp, input logic [DW-1:0] dexp);
        #1;
        chk({tag, ".grant"}, DW'(grant), DW'(gexp));
        chk({tag, ".wren"},  DW'(wren),  DW'(wexp));
        chk({tag, ".ready"}, DW'(req_ready), wexp ? DW'(gexp) : '0);
        chk({tag, ".data"},  wrdata, dexp);
    endtask

    task automatic do_reset();
        req_valid = '0; req_last = '0; full = 1'b0; alm_full = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // reset state
        #2;
        chk("rst.busy", DW'(busy), '0);
        beat("rst", 4'b0000, 1'b0, '0);
        tick();
        reset = 1'b0;

        // T1: req 0, three beats A0..A2
        setreq(0, 1'b1, 1'b0, 128'hA0);
        beat("t1.idle", 4'b0000, 1'b0, '0);
        tick();
        beat("t1.b0", 4'b0001, 1'b1, 128'hA0);
        tick();
        setreq(0, 1'b1, 1'b0, 128'hA1);
        beat("t1.b1", 4'b0001, 1'b1, 128'hA1);
        tick();
        setreq(0, 1'b1, 1'b1, 128'hA2);
        beat("t1.b2", 4'b0001, 1'b1, 128'hA2);
        tick();
        setreq(0, 1'b0, 1'b0, '0);
        #1 chk("t1.end.busy", DW'(busy), '0);

        // T2: all valid, last every beat -> 0,1,2,3,0 with idle gaps
        do_reset();
        for (int k = 0; k < N; k++) setreq(k, 1'b1, 1'b1, DW'(128'hB0 + k));
        for (int j = 0; j < 5; j++) begin
            #1 chk($sformatf("t2.idle%0d", j), DW'(busy), '0);
            tick();
            beat($sformatf("t2.g%0d", j), 4'(1 << (j % N)), 1'b1, DW'(128'hB0 + (j % N)));
            tick();
        end
        req_valid = '0; req_last = '0;

        // T3: req 1 no last, cut at MB beats; re-granted, then req 2 next
        do_reset();
        setreq(1, 1'b1, 1'b0, 128'hC0);
        tick();
        for (int b = 0; b < MB; b++) begin
            setreq(1, 1'b1, 1'b0, DW'(128'hC0 + b));
            beat($sformatf("t3.a%0d", b), 4'b0010, 1'b1, DW'(128'hC0 + b));
            tick();
        end
        #1 chk("t3.cut.busy", DW'(busy), '0);
        tick();
        for (int b = 0; b < MB; b++) begin
            if (b == MB - 1) setreq(2, 1'b1, 1'b1, 128'hE0);
            beat($sformatf("t3.b%0d", b), 4'b0010, 1'b1, DW'(128'hC0 + MB - 1));
            tick();
        end
        #1 chk("t3.cut2.busy", DW'(busy), '0);
        tick();
        beat("t3.req2", 4'b0100, 1'b1, 128'hE0);
        tick();
        req_valid = '0; req_last = '0;

        // T4: full for 3 cycles mid-burst
        do_reset();
        setreq(0, 1'b1, 1'b0, 128'hD0);
        tick();
        beat("t4.b0", 4'b0001, 1'b1, 128'hD0);
        tick();
        setreq(0, 1'b1, 1'b0, 128'hD1);
        full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            beat($sformatf("t4.full%0d", c), 4'b0001, 1'b0, '0);
            tick();
        end
        full = 1'b0;
        beat("t4.b1", 4'b0001, 1'b1, 128'hD1);
        tick();
        setreq(0, 1'b1, 1'b0, 128'hD2);
        beat("t4.b2", 4'b0001, 1'b1, 128'hD2);
        tick();
        setreq(0, 1'b1, 1'b1, 128'hD3);
        beat("t4.b3", 4'b0001, 1'b1, 128'hD3);
        tick();
        req_valid = '0; req_last = '0;
        #1 chk("t4.end.busy", DW'(busy), '0);

        // T5: reset mid-burst, then full burst restarts counter
        do_reset();
        setreq(0, 1'b1, 1'b0, 128'hF0);
        tick();
        beat("t5.b0", 4'b0001, 1'b1, 128'hF0);
        tick();
        beat("t5.b1", 4'b0001, 1'b1, 128'hF0);
        reset = 1'b1;
        beat("t5.rst", 4'b0000, 1'b0, '0);
        chk("t5.rst.busy", DW'(busy), '0);
        tick();
        reset = 1'b0;
        tick();
        for (int b = 0; b < MB; b++) begin
            beat($sformatf("t5.r%0d", b), 4'b0001, 1'b1, 128'hF0);
            tick();
        end
        #1 chk("t5.end.busy", DW'(busy), '0);
        req_valid = '0;

        // T6: almost-full in IDLE
        do_reset();
        alm_full = 1'b1;
        setreq(0, 1'b1, 1'b1, 128'h60);
        tick();
`ifdef FIFO_ARB_ALMFULL_THROTTLE_EN
        beat("t6.hold0", 4'b0000, 1'b0, '0);
        tick();
        beat("t6.hold1", 4'b0000, 1'b0, '0);
        alm_full = 1'b0;
        tick();
        beat("t6.go", 4'b0001, 1'b1, 128'h60);
`else
        beat("t6.go", 4'b0001, 1'b1, 128'h60);
`endif
        tick();
        req_valid = '0; req_last = '0; alm_full = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single 128-bit write port of the team's FIFO among N requesters. Each requester presents beats on a valid/ready handshake; the arbiter grants one requester at a time for a burst, forwards its beats to the FIFO write port, and stalls on FIFO full. It sits between the producer blocks and the FIFO's i_wren/i_wrdata inputs.

## Interface
- N_REQ, 4, number of requesters (2..8)
- DW, 128, data width; matches FIFO i_wrdata
- MAX_BURST, 8, maximum beats per grant (1..255)

- clk  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-high
- i_req_valid  input  N_REQ  per-requester beat valid
- i_req_last  input  N_REQ  per-requester last beat of burst
- i_req_data  input  N_REQ*DW  requester k data at bits [k*DW +: DW]
- o_req_ready  output  N_REQ  per-requester beat accepted this cycle
- i_full  input  1  from FIFO o_full
- i_alm_full  input  1  from FIFO o_alm_full
- o_wren  output  1  to FIFO i_wren
- o_wrdata  output  DW  to FIFO i_wrdata
- o_grant  output  N_REQ  one-hot current owner; 0 when idle
- o_busy  output  1  high while in BURST

## Operation
- States: IDLE, BURST. Registers: state, grant index g, last-owner index p, beat counter (8 bits).
- IDLE: if any i_req_valid, select first k with i_req_valid[k]=1 scanning p+1, p+2, ... mod N_REQ; next edge: g<=k, counter<=0, state<=BURST. No beat transferred in IDLE.
- BURST: beat accepted when i_req_valid[g]=1 and i_full=0; then o_req_ready[g]=1, o_wren=1, o_wrdata=i_req_data[g], counter+1.
- Burst ends on an accepted beat with i_req_last[g]=1, or the accepted beat that makes counter reach MAX_BURST; next edge: p<=g, state<=IDLE.
- Valid dropping mid-burst: grant held, no beat, no timeout.
- i_full=1 in BURST: o_req_ready all 0, o_wren=0; grant held, counter unchanged.
- Non-granted requesters: o_req_ready=0 always.
- o_wrdata = 0 whenever o_wren=0.
- o_grant = one-hot of g in BURST, else 0; o_busy = (state==BURST).

## Timing
- Reset values: state=IDLE, p=N_REQ-1 (requester 0 wins first), counter=0, g=0; all outputs 0.
- Reset asserted mid-burst: immediate return to IDLE, outputs 0 asynchronously; partial burst abandoned.
- Arbitration latency: 1 cycle (IDLE) from first valid to first possible beat.
- Beat path combinational: i_req_valid/i_full -> o_req_ready/o_wren same cycle; zero-cycle data latency.
- Back-to-back bursts: minimum 1 idle cycle between bursts (re-arbitration).
- i_full is relied on to reflect the write of the previous edge; arbiter adds no write slack.
- Single requester continuously valid with last every MAX_BURST beats: throughput MAX_BURST/(MAX_BURST+1).

## Configuration
- FIFO_ARB_ALMFULL_THROTTLE_EN defined: IDLE does not start a new burst while i_alm_full=1 (stays IDLE, p unchanged); bursts in progress continue until last/MAX_BURST or i_full.
- Not defined: i_alm_full ignored; only i_full stalls.

## Test plan
- Reset, then req 0 valid with 3 beats 0xA0..0xA2, last on 3rd -> o_grant=0001 one cycle later, o_wren high 3 consecutive cycles with data A0,A1,A2, then IDLE.
- Reqs 0..3 all valid continuously, last on every beat -> grants in order 0,1,2,3,0, each for 1 beat with 1 idle cycle between.
- MAX_BURST=4, req 1 valid 10 beats, last never asserted -> burst cut after 4 beats; if req 2 valid, req 2 granted next, else req 1 re-granted.
- i_full=1 for 3 cycles mid-burst -> o_wren=0, o_req_ready=0 those cycles, grant held, remaining beats delivered in order after full drops.
- reset pulsed after 2nd of 4 beats -> outputs 0 immediately; after release, req 0 re-granted first with counter restarted.
- Macro defined, i_alm_full=1 in IDLE with req 0 valid -> no grant until i_alm_full=0; undefined -> granted after 1 cycle.
